// File: rtl/output_limiter.sv
// Output limiter: envelope-following gain control, serial Q1.15 multiply, saturation to BITSIZE.
// Latency 20 cycles from sample_valid to out_valid; samples arriving while busy are dropped and flag overrun.
module output_limiter #(
   parameter int BITSIZE = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sample_valid,
   input  logic [BITSIZE-1:0] in_a,
   input  logic [BITSIZE-1:0] in_b,
   input  logic [BITSIZE-1:0] threshold,
   input  logic [3:0]         attack,
   input  logic [3:0]         release_sh,   // "release" is a reserved word
   input  logic               bypass,
   input  logic               overrun_clr,
   output logic [BITSIZE-1:0] out,
   output logic               out_valid,
   output logic               clip,
   output logic               overrun,
   output logic               busy,
   output logic [BITSIZE-1:0] gain
);

   localparam int W  = BITSIZE;
   localparam int CW = $clog2(BITSIZE);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] MAG  = 3'd1;
   localparam logic [2:0] CTRL = 3'd2;
   localparam logic [2:0] MUL  = 3'd3;
   localparam logic [2:0] SAT  = 3'd4;

   localparam logic [W-1:0]          UNITY   = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [2*W:0]   RES_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W:0]   RES_MIN = ~RES_MAX;

   logic [2:0]            state_q, state_d;
   logic [W:0]            sum_q, sum_d;
   logic [W-1:0]          mag_q, mag_d;
   logic [W-1:0]          env_q, env_d;
   logic [W-1:0]          gain_q, gain_d;
   logic signed [2*W:0]   mcand_q, mcand_d;
   logic signed [2*W:0]   acc_q, acc_d;
   logic [W-1:0]          mplier_q, mplier_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [W-1:0]          out_q, out_d;
   logic                  out_valid_q, out_valid_d;
   logic                  clip_q, clip_d;
   logic                  overrun_q, overrun_d;

   logic [W:0]            abs_v;
   logic [W-1:0]          step_v;
   logic [W-1:0]          env_new;
   logic [W-1:0]          gain_new;
   logic signed [2*W:0]   res_v;

   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      mag_d       = mag_q;
      env_d       = env_q;
      gain_d      = gain_q;
      mcand_d     = mcand_q;
      acc_d       = acc_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      clip_d      = clip_q;
      overrun_d   = overrun_q;
      abs_v       = '0;
      step_v      = '0;
      env_new     = env_q;
      gain_new    = gain_q;
      res_v       = acc_q >>> (W-1);

      // Set beats clear when both happen in the same cycle.
      if (sample_valid && state_q != IDLE) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (sample_valid) begin
               sum_d   = {in_a[W-1], in_a} + {in_b[W-1], in_b};
               state_d = MAG;
            end
         end
         MAG: begin
            abs_v   = sum_q[W] ? (~sum_q + 1'b1) : sum_q;
            mag_d   = abs_v[W] ? {W{1'b1}} : abs_v[W-1:0];
            state_d = CTRL;
         end
         CTRL: begin
            if (mag_q > env_q) begin
               env_new = env_q + ((mag_q - env_q) >> attack);
            end else begin
               env_new = env_q - ((env_q - mag_q) >> release_sh);
            end
            if (bypass) begin
               gain_new = UNITY;
            end else if (env_new > threshold) begin
               step_v   = gain_q >> attack;
               if (step_v == '0) step_v = {{(W-1){1'b0}}, 1'b1};
               gain_new = (gain_q > step_v) ? (gain_q - step_v) : '0;
            end else begin
               step_v   = (UNITY - gain_q) >> release_sh;
               if (step_v == '0) step_v = {{(W-1){1'b0}}, 1'b1};
               gain_new = ((UNITY - gain_q) <= step_v) ? UNITY : (gain_q + step_v);
            end
            env_d    = env_new;
            gain_d   = gain_new;
            mplier_d = gain_new;
            mcand_d  = {{W{sum_q[W]}}, sum_q};
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL;
         end
         MUL: begin
            if (mplier_q[0]) acc_d = acc_q + mcand_q;
            mcand_d  = mcand_q <<< 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(W-1)) state_d = SAT;
         end
         SAT: begin
            if (res_v > RES_MAX) begin
               out_d  = {1'b0, {(W-1){1'b1}}};
               clip_d = 1'b1;
            end else if (res_v < RES_MIN) begin
               out_d  = {1'b1, {(W-1){1'b0}}};
               clip_d = 1'b1;
            end else begin
               out_d  = res_v[W-1:0];
               clip_d = 1'b0;
            end
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sum_q       <= '0;
         mag_q       <= '0;
         env_q       <= '0;
         gain_q      <= UNITY;
         mcand_q     <= '0;
         acc_q       <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         clip_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         mag_q       <= mag_d;
         env_q       <= env_d;
         gain_q      <= gain_d;
         mcand_q     <= mcand_d;
         acc_q       <= acc_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         clip_q      <= clip_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign clip      = clip_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE) | out_valid_q;
   assign gain      = gain_q;

endmodule

// File: tb/tb_output_limiter.sv
// Directed bench for output_limiter: hand-computed outputs, gains, latency and overrun behaviour.
module tb_output_limiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        sample_valid;
   logic [15:0] in_a, in_b, threshold;
   logic [3:0]  attack, release_sh;
   logic        bypass, overrun_clr;
   logic [15:0] out, gain;
   logic        out_valid, clip, overrun, busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   output_limiter #(.BITSIZE(16)) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid),
      .in_a(in_a), .in_b(in_b), .threshold(threshold),
      .attack(attack), .release_sh(release_sh),
      .bypass(bypass), .overrun_clr(overrun_clr),
      .out(out), .out_valid(out_valid), .clip(clip),
      .overrun(overrun), .busy(busy), .gain(gain)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      tick;
   endtask

   // Returns the cycle index of out_valid, counting the sample_valid cycle as 0.
   task automatic wait_valid(output int n);
      n = 1;
      while (!out_valid && n < 40) begin
         tick;
         n++;
      end
   endtask

   task automatic run_sample(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] exp_out, input logic exp_clip,
                             input logic [15:0] exp_gain);
      int n;
      in_a = a;
      in_b = b;
      sample_valid = 1'b1;
      tick;
      sample_valid = 1'b0;
      wait_valid(n);
      check({tag, "_lat"},  n,         20);
      check({tag, "_out"},  out,       exp_out);
      check({tag, "_clip"}, clip,      exp_clip);
      check({tag, "_gain"}, gain,      exp_gain);
      tick;
      check({tag, "_pulse"}, out_valid, 1'b0);
      check({tag, "_hold"},  clip,      exp_clip);
   endtask

   initial begin
      int n;
      int cnt;
      rst = 1'b1; sample_valid = 1'b0; in_a = '0; in_b = '0;
      threshold = 16'hFFFF; attack = 4'd4; release_sh = 4'd4;
      bypass = 1'b0; overrun_clr = 1'b0;

      // Reset with a coincident sample_valid that must be ignored.
      tick;
      in_a = 16'h1000; in_b = 16'h1000; sample_valid = 1'b1;
      tick;
      tick;
      check("rst_out",     out,       16'h0000);
      check("rst_valid",   out_valid, 1'b0);
      check("rst_gain",    gain,      16'h8000);
      check("rst_overrun", overrun,   1'b0);
      check("rst_busy",    busy,      1'b0);
      check("rst_clip",    clip,      1'b0);
      rst = 1'b0; sample_valid = 1'b0;
      tick;
      check("rst_sv_ignored", busy, 1'b0);

      // Linear and negative linear paths at unity gain.
      run_sample("lin", 16'h1000, 16'h0800, 16'h1800, 1'b0, 16'h8000);
      run_sample("neg", 16'hF000, 16'hFC00, 16'hEC00, 1'b0, 16'h8000);

      // Bypass forces unity even with threshold 0; saturation still applies.
      bypass = 1'b1; threshold = 16'h0000;
      run_sample("psat",    16'h7000, 16'h2000, 16'h7FFF, 1'b1, 16'h8000);
      run_sample("nsat",    16'h8000, 16'h8000, 16'h8000, 1'b1, 16'h8000);
      run_sample("clipclr", 16'h0100, 16'h0100, 16'h0200, 1'b0, 16'h8000);

      // Hard limit, floor at zero, then full recovery.
      do_reset;
      bypass = 1'b0; threshold = 16'h1000; attack = 4'd0; release_sh = 4'd4;
      run_sample("hard",  16'h1000, 16'h1000, 16'h0000, 1'b0, 16'h0000);
      run_sample("floor", 16'h1000, 16'h1000, 16'h0000, 1'b0, 16'h0000);
      release_sh = 4'd0;
      run_sample("recov", 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h8000);

      // Graded attack: env 1000,1800,1C00 -> gain 8000,4000,2000; then a negative sample.
      do_reset;
      threshold = 16'h1000; attack = 4'd1; release_sh = 4'd4;
      run_sample("att1", 16'h1000, 16'h1000, 16'h2000, 1'b0, 16'h8000);
      run_sample("att2", 16'h1000, 16'h1000, 16'h1000, 1'b0, 16'h4000);
      run_sample("att3", 16'h1000, 16'h1000, 16'h0800, 1'b0, 16'h2000);
      run_sample("att4", 16'hF000, 16'hFC00, 16'hFD80, 1'b0, 16'h1000);

      // Overrun: second sample 5 cycles after the first is dropped.
      do_reset;
      threshold = 16'hFFFF;
      in_a = 16'h0100; in_b = 16'h0100; sample_valid = 1'b1;
      tick;
      sample_valid = 1'b0;
      repeat (4) tick;
      in_a = 16'h2000; sample_valid = 1'b1;
      tick;
      sample_valid = 1'b0;
      check("ovr_set", overrun, 1'b1);
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (out_valid) begin
            cnt++;
            check("ovr_out", out, 16'h0200);
         end
      end
      check("ovr_count", cnt, 1);
      overrun_clr = 1'b1;
      tick;
      overrun_clr = 1'b0;
      check("ovr_clr", overrun, 1'b0);

      // Clear and new overrun in the same cycle: set wins.
      in_a = 16'h0100; in_b = 16'h0000; sample_valid = 1'b1;
      tick;
      overrun_clr = 1'b1;
      tick;
      sample_valid = 1'b0; overrun_clr = 1'b0;
      check("ovr_setwins", overrun, 1'b1);
      wait_valid(n);
      check("ovr_sw_out", out, 16'h0100);
      overrun_clr = 1'b1;
      tick;
      overrun_clr = 1'b0;

      // A sample_valid in the out_valid cycle is accepted without overrun.
      in_a = 16'h0200; in_b = 16'h0000; sample_valid = 1'b1;
      tick;
      sample_valid = 1'b0;
      wait_valid(n);
      check("b2b_first", out, 16'h0200);
      in_a = 16'h0300; sample_valid = 1'b1;
      tick;
      sample_valid = 1'b0;
      wait_valid(n);
      check("b2b_lat", n, 20);
      check("b2b_out", out, 16'h0300);
      check("b2b_noovr", overrun, 1'b0);

      // Reset mid-operation aborts the sample.
      tick;
      in_a = 16'h0400; sample_valid = 1'b1;
      tick;
      sample_valid = 1'b0;
      repeat (7) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick;
         if (out_valid) cnt++;
      end
      check("abort_novalid", cnt, 0);
      check("abort_out", out, 16'h0000);
      check("abort_busy", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
